// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int PC_STEP    = 4;
  localparam int FETCH_XLEN = 32;

  // Entry handed from fetch to decode in a 32-bit core.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [INSTR_W-1:0]    instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry synchronous FIFO with push/pop/flush and occupancy.
// Flush empties the queue by snapping rd_ptr to wr_ptr; flush wins over push/pop.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [W-1:0]                 o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited imem requests, prefetch FIFO, redirect flush.
// Optional FETCH_QUEUE_BYPASS_EN forwards a kept response straight to ID when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [XLEN-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]    id_pc_plus_4
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard_cnt;

  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  entry_t          w_fifo_head;
  entry_t          w_push_data;
  entry_t          w_head;
  logic [CW:0]     w_inflight;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;

  // Credits: queued entries plus responses still owed that will be kept.
  assign w_inflight     = {1'b0, w_fifo_count} + {1'b0, r_outstanding} - {1'b0, r_discard_cnt};
  assign w_redirect_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_req_valid = !rst && !redirect_valid && (w_inflight < DEPTH_C);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_rsp_keep     = !rst && !redirect_valid && imem_rsp_valid && (r_discard_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this edge is stale.
      r_fetch_pc    <= w_redirect_pc;
      r_rsp_pc      <= w_redirect_pc;
      r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
      r_discard_cnt <= r_outstanding - CW'(imem_rsp_valid);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
      if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + XLEN'(PC_STEP);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (r_discard_cnt != '0)) r_discard_cnt <= r_discard_cnt - CW'(1);
    end
  end

  always_comb begin
    w_push_data.pc    = r_rsp_pc;
    w_push_data.instr = imem_rsp_data;
    w_bypass          = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    w_bypass          = w_rsp_keep && w_fifo_empty;
`endif
    w_head       = w_bypass ? w_push_data : w_fifo_head;
    id_valid     = !rst && (!w_fifo_empty || w_bypass);
    id_pc        = id_valid ? w_head.pc : '0;
    id_instr     = id_valid ? w_head.instr : '0;
    id_pc_plus_4 = id_pc + XLEN'(PC_STEP);
  end

  assign w_push = w_rsp_keep && !(w_bypass && id_ready);
  assign w_pop  = !w_fifo_empty && id_ready && !redirect_valid;

  fetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) assert (!(w_push && w_fifo_full));
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order variable-latency memory model and a PC-stream reference.
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int RSP_TO_ID = 0;
`else
  localparam int RSP_TO_ID = 1;
`endif

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus_4;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int          cyc;
  int          last_due;
  int          checks;
  int          errors;

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_pc_plus_4   (id_pc_plus_4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  // Driver: one clock cycle. Inputs change at negedge, outputs are sampled 1 unit later.
  task automatic tick(input bit rs, input bit rq_rdy, input bit idr, input bit redir,
                      input logic [31:0] rpc, input int lat);
    int d;
    @(negedge clk);
    rst            = rs;
    imem_req_ready = rq_rdy;
    id_ready       = idr;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (rs) begin
      mem_q.delete();
      last_due = 0;
    end
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_q.push_back('{addr: imem_req_addr, due: d});
    end
    cyc++;
  endtask

  task automatic do_reset();
    tick(1, 1, 1, 0, 32'h0, 1);
    tick(1, 1, 1, 0, 32'h0, 1);
  endtask

  task automatic test_reset();
    bit found;
    for (int i = 0; i < 3; i++) tick(1, 1, 1, 0, 32'h0, 1);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    checks++; if (id_pc !== 32'h0 || id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_outputs: got pc %h instr %h expected 0 0", id_pc, id_instr); end
    tick(0, 1, 1, 0, 32'h0, 1);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin errors++; $display("FAIL reset_first_req: got v=%b addr %h expected v=1 addr %h", imem_req_valid, imem_req_addr, RESET_PC); end
    tick(0, 1, 0, 0, 32'h0, 2);
    tick(0, 1, 0, 0, 32'h0, 2);
    tick(1, 1, 1, 0, 32'h0, 1);
    checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL reset_midop: got req_v=%b id_v=%b expected 0 0", imem_req_valid, id_valid); end
    tick(1, 1, 1, 0, 32'h0, 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(0, 1, 1, 0, 32'h0, 1);
      if (id_valid) begin
        found = 1'b1;
        checks++; if (id_pc !== RESET_PC) begin errors++; $display("FAIL reset_restart_pc: got %h expected %h", id_pc, RESET_PC); end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL reset_restart_timeout: got no id_valid expected one within 10 cycles"); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick(0, 1, 1, 0, 32'h0, 1);
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin errors++; $display("FAIL stream_req k=%0d: got v=%b addr %h expected v=1 addr %h", k, imem_req_valid, imem_req_addr, 32'(4 * k)); end
      if (k >= 1 + RSP_TO_ID) begin
        e = 32'(4 * (k - 1 - RSP_TO_ID));
        checks++; if (id_valid !== 1'b1 || id_pc !== e || id_instr !== instr_of(e) || id_pc_plus_4 !== e + 32'd4) begin
          errors++; $display("FAIL stream_id k=%0d: got v=%b pc %h instr %h pc4 %h expected v=1 pc %h instr %h pc4 %h", k, id_valid, id_pc, id_instr, id_pc_plus_4, e, instr_of(e), e + 32'd4);
        end
      end else begin
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_idle k=%0d: got id_valid %b expected 0", k, id_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    int          n_acc;
    logic [31:0] e;
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 0, 0, 32'h0, 1);
      if (imem_req_valid && imem_req_ready) n_acc++;
    end
    checks++; if (n_acc !== DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d expected %0d", n_acc, DEPTH); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stall: got %b expected 0", imem_req_valid); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++; $display("FAIL bp_head_hold: got v=%b pc %h expected v=1 pc 0", id_valid, id_pc); end
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'(4 * i));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick(0, 0, 1, 0, 32'h0, 1);
      checks++; if (id_valid !== 1'b1 || id_pc !== e || id_instr !== instr_of(e)) begin errors++; $display("FAIL bp_drain: got v=%b pc %h instr %h expected v=1 pc %h instr %h", id_valid, id_pc, id_instr, e, instr_of(e)); end
    end
    tick(0, 0, 1, 0, 32'h0, 1);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", id_valid); end
  endtask

  task automatic test_redirect_discard();
    bit found;
    do_reset();
    tick(0, 1, 1, 0, 32'h0, 3);
    tick(0, 1, 1, 0, 32'h0, 3);
    tick(0, 0, 1, 1, 32'h100, 3);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_no_req: got %b expected 0", imem_req_valid); end
    tick(0, 1, 1, 0, 32'h0, 3);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL rd_first_req: got v=%b addr %h expected v=1 addr 100", imem_req_valid, imem_req_addr); end
    found = (id_valid === 1'b1);
    checks++; if (found) begin errors++; $display("FAIL rd_stale_early: got id_valid 1 pc %h expected 0", id_pc); end
    for (int i = 0; i < 20 && !found; i++) begin
      tick(0, 1, 1, 0, 32'h0, 3);
      if (id_valid) begin
        found = 1'b1;
        checks++; if (id_pc !== 32'h100 || id_instr !== instr_of(32'h100)) begin errors++; $display("FAIL rd_first_id: got pc %h instr %h expected pc 100 instr %h", id_pc, id_instr, instr_of(32'h100)); end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL rd_timeout: got no id_valid expected one within 20 cycles"); end
  endtask

  task automatic test_redirect_collision();
    bit found;
    do_reset();
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 32'h0, 1);
    tick(0, 1, 1, 1, 32'h203, 1);
    checks++; if (imem_rsp_valid !== 1'b1 || id_valid !== 1'b1) begin errors++; $display("FAIL rc_setup: got rsp=%b id_v=%b expected 1 1", imem_rsp_valid, id_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rc_no_req: got %b expected 0", imem_req_valid); end
    tick(0, 1, 1, 0, 32'h0, 1);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rc_flushed: got id_valid %b pc %h expected 0", id_valid, id_pc); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL rc_aligned_req: got v=%b addr %h expected v=1 addr 200", imem_req_valid, imem_req_addr); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(0, 1, 1, 0, 32'h0, 1);
      if (id_valid) begin
        found = 1'b1;
        checks++; if (id_pc !== 32'h200 || id_instr !== instr_of(32'h200)) begin errors++; $display("FAIL rc_first_id: got pc %h instr %h expected pc 200 instr %h", id_pc, id_instr, instr_of(32'h200)); end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL rc_timeout: got no id_valid expected one within 10 cycles"); end
  endtask

  task automatic test_rsp_latency();
    do_reset();
    tick(0, 1, 1, 0, 32'h0, 1);
    tick(0, 0, 1, 0, 32'h0, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== instr_of(32'h0)) begin errors++; $display("FAIL byp_same_cycle: got v=%b pc %h instr %h expected v=1 pc 0 instr %h", id_valid, id_pc, id_instr, instr_of(32'h0)); end
    tick(0, 0, 1, 0, 32'h0, 1);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL byp_not_queued: got id_valid %b expected 0", id_valid); end
`else
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL lat_same_cycle: got id_valid %b expected 0", id_valid); end
    tick(0, 0, 1, 0, 32'h0, 1);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== instr_of(32'h0)) begin errors++; $display("FAIL lat_next_cycle: got v=%b pc %h instr %h expected v=1 pc 0 instr %h", id_valid, id_pc, id_instr, instr_of(32'h0)); end
`endif
  endtask

  // Reference: ID must see a contiguous +4 PC stream restarting at each aligned redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, exp_req, rpc, prev_pc;
    int          live, consumed, lat;
    bit          rq, idr, redir, prev_hold;
    do_reset();
    exp_pc = RESET_PC; exp_req = RESET_PC;
    live = 0; consumed = 0; prev_hold = 1'b0; prev_pc = '0;
    for (int i = 0; i < 10000; i++) begin
      rq    = ($urandom_range(0, 9) < 7);
      idr   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 99) < 3);
      rpc   = $urandom;
      lat   = $urandom_range(1, 5);
      tick(0, rq, idr, redir, rpc, lat);
      if (prev_hold) begin
        checks++; if (id_valid !== 1'b1 || id_pc !== prev_pc) begin errors++; $display("FAIL rnd_hold i=%0d: got v=%b pc %h expected v=1 pc %h", i, id_valid, id_pc, prev_pc); end
      end
      if (imem_req_valid && imem_req_ready) begin
        checks++; if (imem_req_addr !== exp_req) begin errors++; $display("FAIL rnd_req i=%0d: got %h expected %h", i, imem_req_addr, exp_req); end
        exp_req += 32'd4;
        live++;
      end
      if (id_valid && id_ready && !redir) begin
        checks++; if (id_pc !== exp_pc || id_instr !== instr_of(exp_pc) || id_pc_plus_4 !== exp_pc + 32'd4) begin
          errors++; $display("FAIL rnd_id i=%0d: got pc %h instr %h pc4 %h expected pc %h instr %h pc4 %h", i, id_pc, id_instr, id_pc_plus_4, exp_pc, instr_of(exp_pc), exp_pc + 32'd4);
        end
        exp_pc += 32'd4;
        live--;
        consumed++;
      end
      if (redir) begin
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rnd_redir_req i=%0d: got %b expected 0", i, imem_req_valid); end
        exp_pc  = {rpc[31:2], 2'b00};
        exp_req = {rpc[31:2], 2'b00};
        live    = 0;
      end
      checks++; if (live > DEPTH || live < 0) begin errors++; $display("FAIL rnd_credit i=%0d: got %0d live expected 0..%0d", i, live, DEPTH); end
      prev_hold = id_valid && !id_ready && !redir;
      prev_pc   = id_pc;
    end
    checks++; if (consumed < 2000) begin errors++; $display("FAIL rnd_progress: got %0d consumed expected >= 2000", consumed); end
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    cyc = 0; last_due = 0; checks = 0; errors = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_discard();
    test_redirect_collision();
    test_rsp_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected bench completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
